// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and defaults for the PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int unsigned INSTR_BYTES_DEFAULT  = 4;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
  localparam logic [15:0] TAKEN_COUNT_MAX      = 16'hFFFF;

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - branch destination: pc plus word offset scaled to bytes
module branch_target (
  input  logic [63:0] pc_i,
  input  logic [63:0] offset_i,
  output logic [63:0] target_o
);

  // Shift stays 64 bits wide so the top two offset bits fall off before the add.
  assign target_o = pc_i + (offset_i << 2);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch address sequencer with stall, branch redirect and flush
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        branch_req,
  input  logic        branch_uncond,
  input  logic        branch_zero,
  input  logic [63:0] branch_pc,
  input  logic [63:0] branch_offset,
  output logic [63:0] newDirection,
  output logic        fetch_valid,
  output logic        flush,
  output logic [15:0] taken_count
);

  localparam logic [63:0] PC_INCR = 64'(INSTR_BYTES);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [15:0] count_q, count_d;
  logic [63:0] target;
  logic        taken;

  assign taken = branch_req & (branch_uncond | branch_zero);

  branch_target u_branch_target (
    .pc_i     (branch_pc),
    .offset_i (branch_offset),
    .target_o (target)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_VECTOR;
      count_q <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN, ST_STALL: begin
        // A resolved taken branch wins over any hold condition.
        if (taken) begin
          pc_d    = target;
          state_d = ST_FLUSH;
          if (count_q != TAKEN_COUNT_MAX) begin
            count_d = count_q + 16'd1;
          end
        end else if (stall || !fetch_ready) begin
          state_d = ST_STALL;
        end else begin
          pc_d    = pc_q + PC_INCR;
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == ST_RUN) || (state_q == ST_STALL);
    flush       = (state_q == ST_FLUSH);
  end

  assign newDirection = pc_q;
  assign taken_count  = count_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, is the first fetch address after reset.
REQ-002 Parameter INSTR_BYTES, default 4, is the sequential PC increment.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port stall, input, 1: hazard hold request from the pipeline.
REQ-006 Port fetch_ready, input, 1: instruction memory accepts the current address.
REQ-007 Port branch_req, input, 1: a branch instruction is resolved this cycle.
REQ-008 Port branch_uncond, input, 1: the resolved branch is unconditional.
REQ-009 Port branch_zero, input, 1: ALU zero flag, used for conditional branches.
REQ-010 Port branch_pc, input, 64: address of the resolving branch instruction.
REQ-011 Port branch_offset, input, 64: sign-extended word offset of the branch.
REQ-012 Port newDirection, output, 64: registered next address driven to PC.
REQ-013 Port fetch_valid, output, 1: newDirection is a valid fetch request.
REQ-014 Port flush, output, 1: squash the instruction fetched after a taken branch.
REQ-015 Port taken_count, output, 16: saturating count of taken branches.

Function
REQ-016 taken SHALL be defined as branch_req & (branch_uncond | branch_zero).
REQ-017 The FSM SHALL have the states RESET, RUN, STALL and FLUSH, all registered.
REQ-018 From RESET the FSM SHALL enter RUN on the first cycle with rst_n high, holding newDirection at RESET_VECTOR.
REQ-019 In RUN or STALL with taken set, newDirection SHALL load branch_pc + (branch_offset << 2), using 64-bit modulo arithmetic with the shift truncated to 64 bits, and the FSM SHALL enter FLUSH.
REQ-020 A taken branch SHALL have priority over stall and over fetch_ready low.
REQ-021 In RUN, when taken is clear and either stall is set or fetch_ready is clear, newDirection SHALL hold and the FSM SHALL enter STALL.
REQ-022 In RUN, when taken is clear, stall is clear and fetch_ready is set, newDirection SHALL load newDirection + INSTR_BYTES, modulo 2^64.
REQ-023 In STALL, when taken is clear, stall is clear and fetch_ready is set, newDirection SHALL load newDirection + INSTR_BYTES and the FSM SHALL enter RUN; otherwise it SHALL hold.
REQ-024 FLUSH SHALL last exactly one cycle with flush=1 and fetch_valid=0, hold newDirection, ignore branch_req, and then return to RUN.
REQ-025 fetch_valid SHALL be 1 in RUN and STALL and 0 in RESET and FLUSH; flush SHALL be 1 only in FLUSH.
REQ-026 taken_count SHALL increment by one per accepted taken branch and saturate at 16'hFFFF.
REQ-027 Sequential wrap SHALL be exact: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 64'h0.

Reset
REQ-028 With rst_n low at a clock edge, outputs SHALL become newDirection=RESET_VECTOR, fetch_valid=0, flush=0, taken_count=0, with state RESET.
REQ-029 Reset SHALL override any in-progress STALL or FLUSH, including a branch presented in the same cycle.

Structure
REQ-030 Package pc_seq_pkg SHALL hold the state enum, the INSTR_BYTES default and the RESET_VECTOR default.
REQ-031 Sub-module branch_target SHALL compute branch_pc + (branch_offset << 2) combinationally.

Verification
REQ-032 Reset release, stall=0, fetch_ready=1 -> newDirection steps 0x0, 0x4, 0x8, 0xC on successive cycles, with fetch_valid=1.
REQ-033 stall=1 for 3 cycles at newDirection=0x8 -> newDirection holds 0x8 for 3 cycles, then 0xC one cycle after stall drops.
REQ-034 branch_req=1, branch_uncond=1, branch_pc=0x10, branch_offset=-2 -> newDirection=0x8, one cycle of flush=1 and fetch_valid=0, taken_count+1.
REQ-035 Conditional branch with branch_zero=0 -> not taken, sequential +4, no flush; the same branch with branch_zero=1 and stall=1 -> taken.
REQ-036 newDirection=0xFFFF_FFFF_FFFF_FFFC then an advance -> 0x0; 65536 taken branches -> taken_count saturates at 0xFFFF.
REQ-037 rst_n low during FLUSH or STALL with branch_req=1 -> state RESET, newDirection=0, taken_count=0.
